// File: rtl/time_keeper.sv
// Binary 24 h time-of-day counter with a button-driven set mode (hours, then minutes)
// and a blink flag for the field being edited.
module time_keeper #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_tick,
  output logic [1:0] set_field,
  output logic       blink
);

  localparam int unsigned HALF = TICK_DIV / 2;
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [7:0]    hr_q, hr_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;
  logic          blink_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      presc_q <= '0;
      bcnt_q  <= '0;
      hr_q    <= 8'd0;
      min_q   <= 8'd0;
      sec_q   <= 8'd0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    bcnt_d    = bcnt_q;
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    tick_d    = 1'b0;
    blink_d   = blink_q;
    blink_adv = 1'b0;

    unique case (state_q)
      RUN: begin
        bcnt_d  = '0;
        blink_d = 1'b0;
        if (btn_mode) begin
          state_d = SET_HR;
          presc_d = '0;
        end else if (en) begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            // Full carry chain resolves in a single edge.
            if (sec_q == 8'd59) begin
              sec_d = 8'd0;
              if (min_q == 8'd59) begin
                min_d = 8'd0;
                hr_d  = (hr_q == 8'd23) ? 8'd0 : hr_q + 8'd1;
              end else begin
                min_d = min_q + 8'd1;
              end
            end else begin
              sec_d = sec_q + 8'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      SET_HR: begin
        presc_d = '0;
        if (btn_mode) begin
          state_d = SET_MIN;
          bcnt_d  = '0;
          blink_d = 1'b0;
        end else if (btn_inc) begin
          hr_d    = (hr_q == 8'd23) ? 8'd0 : hr_q + 8'd1;
          bcnt_d  = '0;
          blink_d = 1'b0;
        end else begin
          blink_adv = 1'b1;
        end
      end

      SET_MIN: begin
        presc_d = '0;
        if (btn_mode) begin
          // Leaving set mode restarts the minute at hh:mm:00.
          state_d = RUN;
          sec_d   = 8'd0;
          bcnt_d  = '0;
          blink_d = 1'b0;
        end else if (btn_inc) begin
          min_d   = (min_q == 8'd59) ? 8'd0 : min_q + 8'd1;
          bcnt_d  = '0;
          blink_d = 1'b0;
        end else begin
          blink_adv = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
        presc_d = '0;
        bcnt_d  = '0;
        blink_d = 1'b0;
      end
    endcase

    if (blink_adv) begin
      if (bcnt_q == BLINK_MAX) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  assign hours     = hr_q;
  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign sec_tick  = tick_q;
  assign set_field = state_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV=4: a vector table for the
// free-running count plus hand sequences for freeze, set mode, blink and wrap.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hours, minutes, seconds;
  logic       sec_tick;
  logic [1:0] set_field;
  logic       blink;

  int pass_cnt = 0;
  int total_cnt = 0;

  time_keeper #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .sec_tick (sec_tick),
    .set_field(set_field),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic mode;
    logic inc;
    int   h;
    int   m;
    int   s;
    int   tick;
    int   field;
    int   blk;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkv(input logic e, input int s, input int t);
    vec_t v;
    v.en = e; v.mode = 1'b0; v.inc = 1'b0;
    v.h = 0; v.m = 0; v.s = s; v.tick = t; v.field = 0; v.blk = 0;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step(input logic e, input logic m, input logic i);
    en = e; btn_mode = m; btn_inc = i;
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic chk_time(input string nm, input int h, input int m, input int s);
    chk({nm, " hours"}, int'(hours), h);
    chk({nm, " minutes"}, int'(minutes), m);
    chk({nm, " seconds"}, int'(seconds), s);
  endtask

  initial begin
    // Free-running count from reset: a tick every 4 enabled cycles.
    vecs[0]  = mkv(1'b1, 0, 0);
    vecs[1]  = mkv(1'b1, 0, 0);
    vecs[2]  = mkv(1'b1, 0, 0);
    vecs[3]  = mkv(1'b1, 1, 1);
    vecs[4]  = mkv(1'b1, 1, 0);
    vecs[5]  = mkv(1'b1, 1, 0);
    vecs[6]  = mkv(1'b1, 1, 0);
    vecs[7]  = mkv(1'b1, 2, 1);
    vecs[8]  = mkv(1'b1, 2, 0);
    vecs[9]  = mkv(1'b1, 2, 0);
    vecs[10] = mkv(1'b1, 2, 0);
    vecs[11] = mkv(1'b1, 3, 1);
    vecs[12] = mkv(1'b1, 3, 0);
    vecs[13] = mkv(1'b1, 3, 0);

    // Reset wins over active buttons and enable.
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    en = 1'b0;
    chk_time("reset", 0, 0, 0);
    chk("reset sec_tick", int'(sec_tick), 0);
    chk("reset set_field", int'(set_field), 0);
    chk("reset blink", int'(blink), 0);
    $display("reset: %0d:%0d:%0d field=%0d", hours, minutes, seconds, set_field);

    for (int k = 0; k < 14; k++) begin
      step(vecs[k].en, vecs[k].mode, vecs[k].inc);
      $display("vec %0d: %0d:%0d:%0d tick=%0d field=%0d blink=%0d",
               k, hours, minutes, seconds, sec_tick, set_field, blink);
      chk($sformatf("vec%0d hours", k), int'(hours), vecs[k].h);
      chk($sformatf("vec%0d minutes", k), int'(minutes), vecs[k].m);
      chk($sformatf("vec%0d seconds", k), int'(seconds), vecs[k].s);
      chk($sformatf("vec%0d sec_tick", k), int'(sec_tick), vecs[k].tick);
      chk($sformatf("vec%0d set_field", k), int'(set_field), vecs[k].field);
      chk($sformatf("vec%0d blink", k), int'(blink), vecs[k].blk);
    end

    // Prescaler sits at 2 here; freeze for 20 cycles, then two more enabled edges finish the second.
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("freeze%0d seconds", k), int'(seconds), 3);
      chk($sformatf("freeze%0d sec_tick", k), int'(sec_tick), 0);
    end
    $display("freeze: seconds=%0d after 20 idle cycles", seconds);
    step(1'b1, 1'b0, 1'b0);
    chk("resume1 seconds", int'(seconds), 3);
    chk("resume1 sec_tick", int'(sec_tick), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("resume2 seconds", int'(seconds), 4);
    chk("resume2 sec_tick", int'(sec_tick), 1);
    $display("resume: seconds=%0d tick=%0d", seconds, sec_tick);

    // Set hours: 25 increments wrap 0 -> 1; seconds untouched.
    step(1'b0, 1'b1, 1'b0);
    chk("enter set_hr field", int'(set_field), 1);
    chk("enter set_hr seconds", int'(seconds), 4);
    for (int k = 0; k < 25; k++) step(1'b1, 1'b0, 1'b1);
    chk("set_hr hours", int'(hours), 1);
    chk("set_hr field", int'(set_field), 1);
    chk("set_hr seconds", int'(seconds), 4);
    chk("set_hr sec_tick", int'(sec_tick), 0);
    $display("set_hr: hours=%0d field=%0d", hours, set_field);

    // Mode and inc together: mode wins.
    step(1'b0, 1'b1, 1'b1);
    chk("mode+inc field", int'(set_field), 2);
    chk("mode+inc hours", int'(hours), 1);
    for (int k = 0; k < 61; k++) step(1'b0, 1'b0, 1'b1);
    chk("set_min minutes", int'(minutes), 1);
    chk("set_min field", int'(set_field), 2);
    chk("set_min hours", int'(hours), 1);
    $display("set_min: %0d:%0d field=%0d", hours, minutes, set_field);

    // Blink period is 2 cycles per phase, restarting after the last inc.
    begin
      int exp_b[6] = '{0, 1, 1, 0, 0, 1};
      for (int k = 0; k < 6; k++) begin
        step(1'b0, 1'b0, 1'b0);
        chk($sformatf("blink%0d", k), int'(blink), exp_b[k]);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    chk("inc clears blink", int'(blink), 0);
    chk("inc minutes", int'(minutes), 2);
    $display("blink: after inc blink=%0d minutes=%0d", blink, minutes);

    // Exit to RUN restarts at hh:mm:00; first tick 4 cycles later.
    step(1'b0, 1'b1, 1'b0);
    chk("exit field", int'(set_field), 0);
    chk("exit blink", int'(blink), 0);
    chk_time("exit", 1, 2, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("restart%0d seconds", k), int'(seconds), 0);
      chk($sformatf("restart%0d sec_tick", k), int'(sec_tick), 0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("first tick seconds", int'(seconds), 1);
    chk("first tick sec_tick", int'(sec_tick), 1);
    $display("restart: %0d:%0d:%0d", hours, minutes, seconds);

    // Preload 23:59:xx, run 58 seconds, then watch the full rollover.
    step(1'b0, 1'b1, 1'b0);
    chk("reenter seconds kept", int'(seconds), 1);
    for (int k = 0; k < 22; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 57; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk_time("preload", 23, 59, 0);
    for (int k = 0; k < 232; k++) step(1'b1, 1'b0, 1'b0);
    chk_time("pre-wrap", 23, 59, 58);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0);
    chk_time("last second", 23, 59, 59);
    chk("last second tick", int'(sec_tick), 1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0);
    chk_time("midnight", 0, 0, 0);
    chk("midnight tick", int'(sec_tick), 1);
    $display("rollover: %0d:%0d:%0d", hours, minutes, seconds);

    // Reset during SET_HR.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("pre-reset hours", int'(hours), 1);
    chk("pre-reset field", int'(set_field), 1);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    chk_time("reset in set", 0, 0, 0);
    chk("reset in set field", int'(set_field), 0);
    chk("reset in set blink", int'(blink), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("post-reset field", int'(set_field), 0);
    chk("post-reset seconds", int'(seconds), 0);
    $display("reset in set: %0d:%0d:%0d field=%0d", hours, minutes, seconds, set_field);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
